dcache_port_arbiter: RTL

Shares the single D-cache request port between the load unit (load misses/reads) and the store queue drain (retired stores at the true head). It picks a winner each free slot, returns the accept handshake to the winner, and registers the request into a hold stage that drives the cache until it is accepted. A priority FSM bounds starvation in both directions and forces store drain when the store buffer is near full.

---
 rtl/dcache_port_arbiter.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/dcache_port_arbiter.sv
// dcache_port_arbiter: shares the single D-cache request port between the
// load unit and the store-queue drain. A winner is chosen in every free slot
// and registered into a one-entry hold stage that drives the cache until the
// cache accepts it. The LOAD_PRI / STORE_PRI / DRAIN priority FSM bounds
// starvation in both directions and forces store drain when the store buffer
// fills up.
// Optional build macro: DCACHE_ARB_PERF_EN enables the perf_* grant/conflict
// counters. When it is undefined, perf_* are tied to 0 and no counter flops
// exist.
module dcache_port_arbiter #(
  parameter int STORE_STARVE_LIMIT  = 4,
  parameter int LOAD_STARVE_LIMIT   = 8,
  parameter int DRAIN_HIGH_WATER    = 6,
  parameter int SQ_NUM_ENTRIES_BITS = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           load_req_valid,
  input  logic [31:0]                    load_req_addr,
  output logic                           load_req_accepted,
  input  logic                           store_req_valid,
  input  logic [31:0]                    store_req_addr,
  input  logic [31:0]                    store_req_data,
  input  logic [3:0]                     store_req_byte_mask,
  output logic                           store_req_accepted,
  input  logic [SQ_NUM_ENTRIES_BITS-1:0] store_buffer_count,
  output logic                           dcache_req_valid,
  output logic                           dcache_req_is_store,
  output logic [31:0]                    dcache_req_addr,
  output logic [31:0]                    dcache_req_data,
  output logic [3:0]                     dcache_req_byte_mask,
  input  logic                           dcache_req_ready,
  output logic [31:0]                    perf_load_grants,
  output logic [31:0]                    perf_store_grants,
  output logic [31:0]                    perf_conflict_cycles
);

  localparam int SW = $clog2(STORE_STARVE_LIMIT + 1);
  localparam int LW = $clog2(LOAD_STARVE_LIMIT + 1);

  localparam logic [SW-1:0] STORE_LIM = SW'(STORE_STARVE_LIMIT);
  localparam logic [LW-1:0] LOAD_LIM  = LW'(LOAD_STARVE_LIMIT);
  localparam logic [SQ_NUM_ENTRIES_BITS-1:0] HIGH_WATER =
    SQ_NUM_ENTRIES_BITS'(DRAIN_HIGH_WATER);

  localparam logic [1:0] ST_LOAD_PRI  = 2'd0;
  localparam logic [1:0] ST_STORE_PRI = 2'd1;
  localparam logic [1:0] ST_DRAIN     = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [SW-1:0] store_wait_q, store_wait_d;
  logic [LW-1:0] load_wait_q, load_wait_d;

  logic        hold_valid_q;
  logic        hold_is_store_q;
  logic [31:0] hold_addr_q;
  logic [31:0] hold_data_q;
  logic [3:0]  hold_mask_q;

  logic slot_avail;
  logic both_valid;
  logic grant_load;
  logic grant_store;

  // Pick this slot's winner; accepts stay low while reset is asserted.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    slot_avail  = !reset && (!hold_valid_q || dcache_req_ready);
    both_valid  = load_req_valid && store_req_valid;
    grant_load  = 1'b0;
    grant_store = 1'b0;
    if (slot_avail) begin
      if (both_valid) begin
        case (state_q)
          ST_STORE_PRI: grant_store = 1'b1;
          ST_DRAIN: begin
            if (load_wait_q == LOAD_LIM) grant_load  = 1'b1;
            else                         grant_store = 1'b1;
          end
          default:      grant_load  = 1'b1;
        endcase
      end else begin
        grant_load  = load_req_valid;
        grant_store = store_req_valid;
      end
    end
  end

  assign load_req_accepted  = grant_load;
  assign store_req_accepted = grant_store;

  // Starvation counters and priority FSM advance only in available slots.
  always_comb begin
    state_d      = state_q;
    store_wait_d = store_wait_q;
    load_wait_d  = load_wait_q;
    if (slot_avail) begin
      if (grant_store) begin
        store_wait_d = '0;
      end else if (state_q == ST_LOAD_PRI && store_req_valid &&
                   store_wait_q != STORE_LIM) begin
        store_wait_d = store_wait_q + 1'b1;
      end

      if (grant_load) begin
        load_wait_d = '0;
      end else if (state_q == ST_DRAIN && load_req_valid &&
                   load_wait_q != LOAD_LIM) begin
        load_wait_d = load_wait_q + 1'b1;
      end

      if (store_buffer_count >= HIGH_WATER) begin
        state_d = ST_DRAIN;
      end else begin
        case (state_q)
          ST_LOAD_PRI: begin
            if (store_wait_d == STORE_LIM) state_d = ST_STORE_PRI;
          end
          ST_STORE_PRI: begin
            // One granted store, or the store going away, ends the boost.
            if (grant_store || !store_req_valid) begin
              state_d      = ST_LOAD_PRI;
              store_wait_d = '0;
            end
          end
          ST_DRAIN: begin
            if (store_buffer_count == '0) begin
              state_d     = ST_LOAD_PRI;
              load_wait_d = '0;
            end
          end
          default: state_d = ST_LOAD_PRI;
        endcase
      end
    end
  end

  // FSM and starvation counter registers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_LOAD_PRI;
      store_wait_q <= '0;
      load_wait_q  <= '0;
    end else begin
      state_q      <= state_d;
      store_wait_q <= store_wait_d;
      load_wait_q  <= load_wait_d;
    end
  end

  // Hold stage: load the winner, clear on an empty slot, freeze while stalled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_valid_q    <= 1'b0;
      hold_is_store_q <= 1'b0;
      hold_addr_q     <= '0;
      hold_data_q     <= '0;
      hold_mask_q     <= '0;
    end else if (slot_avail) begin
      hold_valid_q    <= grant_load || grant_store;
      hold_is_store_q <= grant_store;
      if (grant_store) begin
        hold_addr_q <= store_req_addr;
        hold_data_q <= store_req_data;
        hold_mask_q <= store_req_byte_mask;
      end else if (grant_load) begin
        hold_addr_q <= load_req_addr;
        hold_data_q <= '0;
        hold_mask_q <= 4'hF;
      end else begin
        hold_addr_q <= '0;
        hold_data_q <= '0;
        hold_mask_q <= '0;
      end
    end
  end

  assign dcache_req_valid     = hold_valid_q;
  assign dcache_req_is_store  = hold_is_store_q;
  assign dcache_req_addr      = hold_addr_q;
  assign dcache_req_data      = hold_data_q;
  assign dcache_req_byte_mask = hold_mask_q;

`ifdef DCACHE_ARB_PERF_EN
  logic [31:0] perf_load_q, perf_store_q, perf_conflict_q;

  // Free-running performance counters, wrapping at 2^32.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_load_q     <= '0;
      perf_store_q    <= '0;
      perf_conflict_q <= '0;
    end else begin
      if (grant_load)                perf_load_q     <= perf_load_q + 32'd1;
      if (grant_store)               perf_store_q    <= perf_store_q + 32'd1;
      if (slot_avail && both_valid)  perf_conflict_q <= perf_conflict_q + 32'd1;
    end
  end

  assign perf_load_grants     = perf_load_q;
  assign perf_store_grants    = perf_store_q;
  assign perf_conflict_cycles = perf_conflict_q;
`else
  assign perf_load_grants     = '0;
  assign perf_store_grants    = '0;
  assign perf_conflict_cycles = '0;
`endif

endmodule
